// File: rtl/l2_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : l2_read_arbiter
//  Description : Shares one L2 read port (address + burst data) between the
//                instruction and data caches. It registers the winning
//                address and steers each returning burst to the requester
//                that owns it, using an in-order owner FIFO.
//                Optional macro L2_ARB_ROUND_ROBIN_EN enables round-robin
//                arbitration; without it, INS has fixed priority over DAT.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_read_arbiter #(
    parameter int unsigned W               = 7,
    parameter int unsigned B               = 9,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic [29:0]         INS_ADDR_TO_L2,
    input  logic                INS_ADDR_TO_L2_VALID,
    output logic                INS_ADDR_TO_L2_READY,
    input  logic [29:0]         DAT_ADDR_TO_L2,
    input  logic                DAT_ADDR_TO_L2_VALID,
    output logic                DAT_ADDR_TO_L2_READY,
    output logic [29:0]         ADDR_TO_L2,
    output logic                ADDR_TO_L2_VALID,
    input  logic                ADDR_TO_L2_READY,
    input  logic [(2**W)-1:0]   DATA_FROM_L2,
    input  logic                DATA_FROM_L2_VALID,
    output logic                DATA_FROM_L2_READY,
    output logic [(2**W)-1:0]   INS_DATA_FROM_L2,
    output logic                INS_DATA_FROM_L2_VALID,
    input  logic                INS_DATA_FROM_L2_READY,
    output logic [(2**W)-1:0]   DAT_DATA_FROM_L2,
    output logic                DAT_DATA_FROM_L2_VALID,
    input  logic                DAT_DATA_FROM_L2_READY,
    output logic                ORPHAN_BEAT
);

    localparam int unsigned          c_beat_w    = B - W;
    localparam int unsigned          c_ptr_w     = $clog2(MAX_OUTSTANDING);
    localparam int unsigned          c_cnt_w     = c_ptr_w + 1;
    // L2_BURST is a power of two, so the final beat index is all ones
    localparam logic [c_beat_w-1:0]  c_last_beat = {c_beat_w{1'b1}};
    localparam logic [c_cnt_w-1:0]   c_depth     = c_cnt_w'(MAX_OUTSTANDING);

    logic [29:0]          r_addr;
    logic                 r_addr_valid;
    logic                 r_owner [MAX_OUTSTANDING];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_beat_w-1:0]  r_beat_cnt;
    logic                 r_orphan;

    logic w_load_en;
    logic w_full;
    logic w_empty;
    logic w_pick_dat;
    logic w_grant_ins;
    logic w_grant_dat;
    logic w_push;
    logic w_head;
    logic w_beat;
    logic w_pop;

    assign w_load_en = !r_addr_valid | ADDR_TO_L2_READY;
    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);

`ifdef L2_ARB_ROUND_ROBIN_EN
    logic w_both;
    logic r_prefer_dat;

    assign w_both     = INS_ADDR_TO_L2_VALID & DAT_ADDR_TO_L2_VALID;
    assign w_pick_dat = w_both ? r_prefer_dat : DAT_ADDR_TO_L2_VALID;

    // Only contested grants move the pointer: the loser gets the next one
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_prefer_dat <= 1'b0;
        end else if (w_push && w_both) begin
            r_prefer_dat <= !w_pick_dat;
        end
    end
`else
    assign w_pick_dat = DAT_ADDR_TO_L2_VALID & !INS_ADDR_TO_L2_VALID;
`endif

    assign w_grant_ins = w_load_en & !w_full & INS_ADDR_TO_L2_VALID & !w_pick_dat;
    assign w_grant_dat = w_load_en & !w_full & DAT_ADDR_TO_L2_VALID & w_pick_dat;
    assign w_push      = w_grant_ins | w_grant_dat;

    assign INS_ADDR_TO_L2_READY = w_grant_ins;
    assign DAT_ADDR_TO_L2_READY = w_grant_dat;
    assign ADDR_TO_L2           = r_addr;
    assign ADDR_TO_L2_VALID     = r_addr_valid;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
        end else if (w_push) begin
            r_addr       <= w_grant_dat ? DAT_ADDR_TO_L2 : INS_ADDR_TO_L2;
            r_addr_valid <= 1'b1;
        end else if (w_load_en) begin
            r_addr_valid <= 1'b0;
        end
    end

    // Return steering: the FIFO head names the owner of the burst in flight
    assign w_head = r_owner[r_rd_ptr];

    assign INS_DATA_FROM_L2       = DATA_FROM_L2;
    assign DAT_DATA_FROM_L2       = DATA_FROM_L2;
    assign INS_DATA_FROM_L2_VALID = DATA_FROM_L2_VALID & !w_empty & !w_head;
    assign DAT_DATA_FROM_L2_VALID = DATA_FROM_L2_VALID & !w_empty & w_head;
    assign DATA_FROM_L2_READY     = w_empty ? 1'b1
                                  : (w_head ? DAT_DATA_FROM_L2_READY : INS_DATA_FROM_L2_READY);

    assign w_beat = DATA_FROM_L2_VALID & DATA_FROM_L2_READY & !w_empty;
    assign w_pop  = w_beat & (r_beat_cnt == c_last_beat);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_owner[r_wr_ptr] <= w_grant_dat;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
            r_orphan   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_beat) begin
                r_beat_cnt <= w_pop ? '0 : r_beat_cnt + c_beat_w'(1);
            end
            if (DATA_FROM_L2_VALID && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    assign ORPHAN_BEAT = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_l2_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_l2_read_arbiter
//  Description : Scoreboard bench for l2_read_arbiter (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_read_arbiter;

    localparam int DW = 128;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic [29:0]   INS_ADDR_TO_L2;
    logic          INS_ADDR_TO_L2_VALID;
    logic          INS_ADDR_TO_L2_READY;
    logic [29:0]   DAT_ADDR_TO_L2;
    logic          DAT_ADDR_TO_L2_VALID;
    logic          DAT_ADDR_TO_L2_READY;
    logic [29:0]   ADDR_TO_L2;
    logic          ADDR_TO_L2_VALID;
    logic          ADDR_TO_L2_READY;
    logic [DW-1:0] DATA_FROM_L2;
    logic          DATA_FROM_L2_VALID;
    logic          DATA_FROM_L2_READY;
    logic [DW-1:0] INS_DATA_FROM_L2;
    logic          INS_DATA_FROM_L2_VALID;
    logic          INS_DATA_FROM_L2_READY;
    logic [DW-1:0] DAT_DATA_FROM_L2;
    logic          DAT_DATA_FROM_L2_VALID;
    logic          DAT_DATA_FROM_L2_READY;
    logic          ORPHAN_BEAT;

    int total = 0;
    int bad   = 0;

    logic [29:0]   addr_q [$];
    bit            own_q  [$];
    logic [DW-1:0] beat_q [$];

    l2_read_arbiter dut (
        .CLK                    (CLK),
        .RSTN                   (RSTN),
        .INS_ADDR_TO_L2         (INS_ADDR_TO_L2),
        .INS_ADDR_TO_L2_VALID   (INS_ADDR_TO_L2_VALID),
        .INS_ADDR_TO_L2_READY   (INS_ADDR_TO_L2_READY),
        .DAT_ADDR_TO_L2         (DAT_ADDR_TO_L2),
        .DAT_ADDR_TO_L2_VALID   (DAT_ADDR_TO_L2_VALID),
        .DAT_ADDR_TO_L2_READY   (DAT_ADDR_TO_L2_READY),
        .ADDR_TO_L2             (ADDR_TO_L2),
        .ADDR_TO_L2_VALID       (ADDR_TO_L2_VALID),
        .ADDR_TO_L2_READY       (ADDR_TO_L2_READY),
        .DATA_FROM_L2           (DATA_FROM_L2),
        .DATA_FROM_L2_VALID     (DATA_FROM_L2_VALID),
        .DATA_FROM_L2_READY     (DATA_FROM_L2_READY),
        .INS_DATA_FROM_L2       (INS_DATA_FROM_L2),
        .INS_DATA_FROM_L2_VALID (INS_DATA_FROM_L2_VALID),
        .INS_DATA_FROM_L2_READY (INS_DATA_FROM_L2_READY),
        .DAT_DATA_FROM_L2       (DAT_DATA_FROM_L2),
        .DAT_DATA_FROM_L2_VALID (DAT_DATA_FROM_L2_VALID),
        .DAT_DATA_FROM_L2_READY (DAT_DATA_FROM_L2_READY),
        .ORPHAN_BEAT            (ORPHAN_BEAT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one 4-beat burst to the owner at the head of own_q; optional
    // stall on one beat and optional DAT request alongside the final beat.
    task automatic drive_burst(input logic [31:0] seed, input int stall_beat,
                               input int stall_cycles, input bit req_on_last,
                               input logic [29:0] req_addr);
        bit            owner;
        logic [31:0]   w;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] got_d;
        logic [29:0]   exp_a;
        if (own_q.size() == 0) begin
            total++; bad++;
            $display("FAIL burst_owner: no owner queued, required one");
            return;
        end
        owner = own_q.pop_front();
        for (int b = 0; b < 4; b++) begin
            w = seed + 32'(b);
            DATA_FROM_L2       = {4{w}};
            DATA_FROM_L2_VALID = 1'b1;
            beat_q.push_back({4{w}});
            if (b == stall_beat) begin
                if (owner) DAT_DATA_FROM_L2_READY = 1'b0;
                else       INS_DATA_FROM_L2_READY = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    #1;
                    total++;
                    if (DATA_FROM_L2_READY !== 1'b0 ||
                        (owner ? DAT_DATA_FROM_L2_VALID : INS_DATA_FROM_L2_VALID) !== 1'b1) begin
                        bad++;
                        $display("FAIL stall_hold beat%0d: ready=%b valid=%b, required ready=0 valid=1",
                                 b, DATA_FROM_L2_READY,
                                 owner ? DAT_DATA_FROM_L2_VALID : INS_DATA_FROM_L2_VALID);
                    end
                    tick();
                end
                INS_DATA_FROM_L2_READY = 1'b1;
                DAT_DATA_FROM_L2_READY = 1'b1;
            end
            if (req_on_last && b == 3) begin
                DAT_ADDR_TO_L2       = req_addr;
                DAT_ADDR_TO_L2_VALID = 1'b1;
                addr_q.push_back(req_addr);
                own_q.push_back(1'b1);
            end
            #1;
            total++;
            exp_d = beat_q.pop_front();
            got_d = owner ? DAT_DATA_FROM_L2 : INS_DATA_FROM_L2;
            if ((owner ? DAT_DATA_FROM_L2_VALID : INS_DATA_FROM_L2_VALID) !== 1'b1 ||
                (owner ? INS_DATA_FROM_L2_VALID : DAT_DATA_FROM_L2_VALID) !== 1'b0 ||
                DATA_FROM_L2_READY !== 1'b1 || got_d !== exp_d) begin
                bad++;
                $display("FAIL beat%0d owner=%0d: ins_v=%b dat_v=%b rdy=%b data=%h, required data=%h",
                         b, owner, INS_DATA_FROM_L2_VALID, DAT_DATA_FROM_L2_VALID,
                         DATA_FROM_L2_READY, got_d, exp_d);
            end
            if (req_on_last && b == 3) begin
                total++;
                if (DAT_ADDR_TO_L2_READY !== 1'b1) begin
                    bad++;
                    $display("FAIL grant_with_pop: dat_ready=%b, required 1", DAT_ADDR_TO_L2_READY);
                end
            end
            tick();
            if (req_on_last && b == 3) begin
                DAT_ADDR_TO_L2_VALID = 1'b0;
                exp_a = addr_q.pop_front();
                total++;
                if (ADDR_TO_L2_VALID !== 1'b1 || ADDR_TO_L2 !== exp_a) begin
                    bad++;
                    $display("FAIL addr_with_pop: valid=%b addr=%h, required 1 %h",
                             ADDR_TO_L2_VALID, ADDR_TO_L2, exp_a);
                end
            end
        end
        DATA_FROM_L2_VALID = 1'b0;
    endtask

    task automatic test_reset();
        INS_ADDR_TO_L2 = '0; INS_ADDR_TO_L2_VALID = 1'b0;
        DAT_ADDR_TO_L2 = '0; DAT_ADDR_TO_L2_VALID = 1'b0;
        ADDR_TO_L2_READY = 1'b1;
        DATA_FROM_L2 = '0; DATA_FROM_L2_VALID = 1'b0;
        INS_DATA_FROM_L2_READY = 1'b1; DAT_DATA_FROM_L2_READY = 1'b1;
        RSTN = 1'b0;
        tick(); tick();
        total++;
        if (ADDR_TO_L2_VALID !== 1'b0 || ADDR_TO_L2 !== 30'h0) begin
            bad++;
            $display("FAIL reset_addr: valid=%b addr=%h, required 0 0", ADDR_TO_L2_VALID, ADDR_TO_L2);
        end
        total++;
        if (ORPHAN_BEAT !== 1'b0) begin
            bad++;
            $display("FAIL reset_orphan: got %b, required 0", ORPHAN_BEAT);
        end
        total++;
        if (DATA_FROM_L2_READY !== 1'b1) begin
            bad++;
            $display("FAIL reset_data_ready: got %b, required 1", DATA_FROM_L2_READY);
        end
        total++;
        if (INS_ADDR_TO_L2_READY !== 1'b0 || DAT_ADDR_TO_L2_READY !== 1'b0) begin
            bad++;
            $display("FAIL reset_req_ready: ins=%b dat=%b, required 0 0",
                     INS_ADDR_TO_L2_READY, DAT_ADDR_TO_L2_READY);
        end
        RSTN = 1'b1;
        tick();
    endtask

    task automatic test_single_ins();
        logic [29:0] exp_a;
        INS_ADDR_TO_L2 = 30'h0000_1234; INS_ADDR_TO_L2_VALID = 1'b1;
        addr_q.push_back(30'h0000_1234); own_q.push_back(1'b0);
        #1;
        total++;
        if (INS_ADDR_TO_L2_READY !== 1'b1 || DAT_ADDR_TO_L2_READY !== 1'b0) begin
            bad++;
            $display("FAIL single_grant: ins=%b dat=%b, required 1 0",
                     INS_ADDR_TO_L2_READY, DAT_ADDR_TO_L2_READY);
        end
        tick();
        INS_ADDR_TO_L2_VALID = 1'b0;
        exp_a = addr_q.pop_front();
        total++;
        if (ADDR_TO_L2_VALID !== 1'b1 || ADDR_TO_L2 !== exp_a) begin
            bad++;
            $display("FAIL single_addr: valid=%b addr=%h, required 1 %h", ADDR_TO_L2_VALID, ADDR_TO_L2, exp_a);
        end
        tick();
        total++;
        if (ADDR_TO_L2_VALID !== 1'b0) begin
            bad++;
            $display("FAIL single_addr_drop: valid=%b, required 0", ADDR_TO_L2_VALID);
        end
        drive_burst(32'hA000_0000, -1, 0, 1'b0, 30'h0);
        INS_DATA_FROM_L2_READY = 1'b0;
        #1;
        total++;
        if (DATA_FROM_L2_READY !== 1'b1) begin
            bad++;
            $display("FAIL single_fifo_empty: data_ready=%b, required 1", DATA_FROM_L2_READY);
        end
        INS_DATA_FROM_L2_READY = 1'b1;
        tick();
    endtask

    task automatic test_arbitration();
        bit          e;
        logic [29:0] exp_a;
        INS_ADDR_TO_L2 = 30'h100; DAT_ADDR_TO_L2 = 30'h200;
        INS_ADDR_TO_L2_VALID = 1'b1; DAT_ADDR_TO_L2_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            e = (k % 2) == 1;
`else
            e = 1'b0;
`endif
            addr_q.push_back(e ? 30'h200 : 30'h100);
            own_q.push_back(e);
            #1;
            total++;
            if (INS_ADDR_TO_L2_READY !== !e || DAT_ADDR_TO_L2_READY !== e) begin
                bad++;
                $display("FAIL arb_grant%0d: ins=%b dat=%b, required %b %b",
                         k, INS_ADDR_TO_L2_READY, DAT_ADDR_TO_L2_READY, !e, e);
            end
            tick();
            exp_a = addr_q.pop_front();
            total++;
            if (ADDR_TO_L2_VALID !== 1'b1 || ADDR_TO_L2 !== exp_a) begin
                bad++;
                $display("FAIL arb_addr%0d: addr=%h, required %h", k, ADDR_TO_L2, exp_a);
            end
        end
        INS_ADDR_TO_L2_VALID = 1'b0; DAT_ADDR_TO_L2_VALID = 1'b0;
        for (int k = 0; k < 4; k++) drive_burst(32'hB000_0000 + 32'(k * 16), -1, 0, 1'b0, 30'h0);
        tick();
    endtask

    task automatic test_addr_stall();
        logic [29:0] exp_a;
        ADDR_TO_L2_READY = 1'b0;
        INS_ADDR_TO_L2 = 30'h500; INS_ADDR_TO_L2_VALID = 1'b1;
        addr_q.push_back(30'h500); own_q.push_back(1'b0);
        tick();
        INS_ADDR_TO_L2_VALID = 1'b0;
        DAT_ADDR_TO_L2 = 30'h600; DAT_ADDR_TO_L2_VALID = 1'b1;
        exp_a = addr_q.pop_front();
        for (int s = 0; s < 5; s++) begin
            #1;
            total++;
            if (ADDR_TO_L2_VALID !== 1'b1 || ADDR_TO_L2 !== exp_a || DAT_ADDR_TO_L2_READY !== 1'b0) begin
                bad++;
                $display("FAIL stall_addr%0d: valid=%b addr=%h dat_ready=%b, required 1 %h 0",
                         s, ADDR_TO_L2_VALID, ADDR_TO_L2, DAT_ADDR_TO_L2_READY, exp_a);
            end
            tick();
        end
        ADDR_TO_L2_READY = 1'b1;
        addr_q.push_back(30'h600); own_q.push_back(1'b1);
        #1;
        total++;
        if (DAT_ADDR_TO_L2_READY !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: dat_ready=%b, required 1", DAT_ADDR_TO_L2_READY);
        end
        tick();
        DAT_ADDR_TO_L2_VALID = 1'b0;
        exp_a = addr_q.pop_front();
        total++;
        if (ADDR_TO_L2_VALID !== 1'b1 || ADDR_TO_L2 !== exp_a) begin
            bad++;
            $display("FAIL stall_next_addr: addr=%h, required %h", ADDR_TO_L2, exp_a);
        end
        drive_burst(32'hC000_0000, -1, 0, 1'b0, 30'h0);
        drive_burst(32'hC100_0000, -1, 0, 1'b0, 30'h0);
        tick();
    endtask

    task automatic test_fifo_full();
        bit            owner;
        logic [29:0]   exp_a;
        logic [DW-1:0] exp_d;
        for (int k = 0; k < 4; k++) begin
            INS_ADDR_TO_L2 = 30'h300 + 30'(k); DAT_ADDR_TO_L2 = 30'h300 + 30'(k);
            INS_ADDR_TO_L2_VALID = (k % 2) == 0;
            DAT_ADDR_TO_L2_VALID = (k % 2) == 1;
            addr_q.push_back(30'h300 + 30'(k)); own_q.push_back((k % 2) == 1);
            tick();
            exp_a = addr_q.pop_front();
            total++;
            if (ADDR_TO_L2_VALID !== 1'b1 || ADDR_TO_L2 !== exp_a) begin
                bad++;
                $display("FAIL full_fill%0d: valid=%b addr=%h, required 1 %h", k, ADDR_TO_L2_VALID, ADDR_TO_L2, exp_a);
            end
        end
        DAT_ADDR_TO_L2_VALID = 1'b0;
        INS_ADDR_TO_L2 = 30'h400; INS_ADDR_TO_L2_VALID = 1'b1;
        owner = own_q.pop_front();
        for (int b = 0; b < 4; b++) begin
            DATA_FROM_L2 = {4{32'hD000_0000 + 32'(b)}};
            DATA_FROM_L2_VALID = 1'b1;
            beat_q.push_back({4{32'hD000_0000 + 32'(b)}});
            #1;
            exp_d = beat_q.pop_front();
            total++;
            if (INS_ADDR_TO_L2_READY !== 1'b0 || INS_DATA_FROM_L2_VALID !== !owner ||
                INS_DATA_FROM_L2 !== exp_d) begin
                bad++;
                $display("FAIL full_refuse%0d: ins_ready=%b ins_v=%b data=%h, required 0 %b %h",
                         b, INS_ADDR_TO_L2_READY, INS_DATA_FROM_L2_VALID, INS_DATA_FROM_L2, !owner, exp_d);
            end
            tick();
        end
        DATA_FROM_L2_VALID = 1'b0;
        addr_q.push_back(30'h400); own_q.push_back(1'b0);
        #1;
        total++;
        if (INS_ADDR_TO_L2_READY !== 1'b1) begin
            bad++;
            $display("FAIL full_after_pop: ins_ready=%b, required 1", INS_ADDR_TO_L2_READY);
        end
        tick();
        INS_ADDR_TO_L2_VALID = 1'b0;
        exp_a = addr_q.pop_front();
        total++;
        if (ADDR_TO_L2_VALID !== 1'b1 || ADDR_TO_L2 !== exp_a) begin
            bad++;
            $display("FAIL full_fifth_addr: addr=%h, required %h", ADDR_TO_L2, exp_a);
        end
        for (int k = 0; k < 4; k++) drive_burst(32'hE000_0000 + 32'(k * 16), -1, 0, 1'b0, 30'h0);
        tick();
    endtask

    task automatic test_data_stall();
        INS_ADDR_TO_L2 = 30'hABC; INS_ADDR_TO_L2_VALID = 1'b1;
        addr_q.push_back(30'hABC); own_q.push_back(1'b0);
        tick();
        INS_ADDR_TO_L2_VALID = 1'b0;
        void'(addr_q.pop_front());
        drive_burst(32'hF000_0000, 2, 3, 1'b0, 30'h0);
        INS_DATA_FROM_L2_READY = 1'b0;
        #1;
        total++;
        if (DATA_FROM_L2_READY !== 1'b1) begin
            bad++;
            $display("FAIL stall_complete: data_ready=%b, required 1 (fifo empty)", DATA_FROM_L2_READY);
        end
        INS_DATA_FROM_L2_READY = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        INS_ADDR_TO_L2 = 30'h800; INS_ADDR_TO_L2_VALID = 1'b1;
        addr_q.push_back(30'h800); own_q.push_back(1'b0);
        tick();
        INS_ADDR_TO_L2_VALID = 1'b0;
        void'(addr_q.pop_front());
        drive_burst(32'h1100_0000, -1, 0, 1'b1, 30'h900);
        drive_burst(32'h2200_0000, -1, 0, 1'b0, 30'h0);
        tick();
    endtask

    task automatic test_orphan();
        total++;
        if (ORPHAN_BEAT !== 1'b0) begin
            bad++;
            $display("FAIL orphan_idle: got %b, required 0", ORPHAN_BEAT);
        end
        DATA_FROM_L2 = {4{32'h0BAD_0000}}; DATA_FROM_L2_VALID = 1'b1;
        #1;
        total++;
        if (DATA_FROM_L2_READY !== 1'b1 || INS_DATA_FROM_L2_VALID !== 1'b0 || DAT_DATA_FROM_L2_VALID !== 1'b0) begin
            bad++;
            $display("FAIL orphan_steer: rdy=%b ins_v=%b dat_v=%b, required 1 0 0",
                     DATA_FROM_L2_READY, INS_DATA_FROM_L2_VALID, DAT_DATA_FROM_L2_VALID);
        end
        tick();
        DATA_FROM_L2_VALID = 1'b0;
        tick(); tick();
        total++;
        if (ORPHAN_BEAT !== 1'b1) begin
            bad++;
            $display("FAIL orphan_sticky: got %b, required 1", ORPHAN_BEAT);
        end
        RSTN = 1'b0;
        #1;
        total++;
        if (ORPHAN_BEAT !== 1'b0) begin
            bad++;
            $display("FAIL orphan_async_clear: got %b, required 0", ORPHAN_BEAT);
        end
        RSTN = 1'b1;
        tick();
        // reset in the middle of a DAT burst
        DAT_ADDR_TO_L2 = 30'h700; DAT_ADDR_TO_L2_VALID = 1'b1;
        tick();
        DAT_ADDR_TO_L2_VALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            DATA_FROM_L2 = {4{32'h7000_0000 + 32'(b)}}; DATA_FROM_L2_VALID = 1'b1;
            #1;
            total++;
            if (DAT_DATA_FROM_L2_VALID !== 1'b1) begin
                bad++;
                $display("FAIL midreset_pre%0d: dat_v=%b, required 1", b, DAT_DATA_FROM_L2_VALID);
            end
            tick();
        end
        RSTN = 1'b0;
        #1;
        RSTN = 1'b1;
        for (int b = 2; b < 4; b++) begin
            DATA_FROM_L2 = {4{32'h7000_0000 + 32'(b)}};
            #1;
            total++;
            if (DAT_DATA_FROM_L2_VALID !== 1'b0 || INS_DATA_FROM_L2_VALID !== 1'b0 || DATA_FROM_L2_READY !== 1'b1) begin
                bad++;
                $display("FAIL midreset_post%0d: dat_v=%b ins_v=%b rdy=%b, required 0 0 1",
                         b, DAT_DATA_FROM_L2_VALID, INS_DATA_FROM_L2_VALID, DATA_FROM_L2_READY);
            end
            tick();
        end
        DATA_FROM_L2_VALID = 1'b0;
        total++;
        if (ORPHAN_BEAT !== 1'b1) begin
            bad++;
            $display("FAIL midreset_orphan: got %b, required 1", ORPHAN_BEAT);
        end
        own_q.delete(); beat_q.delete(); addr_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_ins();
        test_arbitration();
        test_addr_stall();
        test_fifo_full();
        test_data_stall();
        test_back_to_back();
        test_orphan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
